// File: rtl/output_port_vc_allocator.sv
// Output-port VC allocator: round-robin input arbitration, per-VC credit tracking
// and VC selection (preferred VC first, else highest-index VC with a free slot).
module output_port_vc_allocator #(
    parameter int unsigned INPUT_NUM       = 5,
    parameter int unsigned OUTPUT_VC_NUM   = 4,
    parameter int unsigned OUTPUT_VC_DEPTH = 2,
    localparam int unsigned VC_IDX_W = (OUTPUT_VC_NUM > 1) ? $clog2(OUTPUT_VC_NUM) : 1,
    localparam int unsigned CNT_W    = $clog2(OUTPUT_VC_DEPTH + 1),
    localparam int unsigned IN_IDX_W = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic [INPUT_NUM-1:0]                    req_vld_i,
    input  logic [INPUT_NUM-1:0][VC_IDX_W-1:0]      req_pref_vc_i,
    input  logic [OUTPUT_VC_NUM-1:0]                credit_ret_vld_i,
    output logic [INPUT_NUM-1:0]                    gnt_o,
    output logic [VC_IDX_W-1:0]                     gnt_vc_id_o,
    output logic [IN_IDX_W-1:0]                     gnt_in_id_o,
    output logic [OUTPUT_VC_NUM-1:0][CNT_W-1:0]     vc_credit_counter_o,
    output logic                                    credit_err_o
);

    localparam logic [CNT_W-1:0]    CntMax  = CNT_W'(OUTPUT_VC_DEPTH);
    localparam logic [CNT_W-1:0]    CntOne  = CNT_W'(1);
    localparam logic [IN_IDX_W-1:0] LastIn  = IN_IDX_W'(INPUT_NUM - 1);
    localparam logic [IN_IDX_W-1:0] InOne   = IN_IDX_W'(1);

    logic [OUTPUT_VC_NUM-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [IN_IDX_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic                                err_q, err_d;

    logic                win_found;
    logic [IN_IDX_W-1:0] win_idx;
    logic [VC_IDX_W-1:0] pref_vc;
    logic                vc_found;
    logic [VC_IDX_W-1:0] sel_vc;
    logic                gnt_valid;

    // Round-robin search starting at rr_ptr, wrapping past the last input.
    always_comb begin
        int k;
        k         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < int'(INPUT_NUM); i++) begin
            k = int'(rr_ptr_q) + i;
            if (k >= int'(INPUT_NUM)) k = k - int'(INPUT_NUM);
            if (!win_found && req_vld_i[IN_IDX_W'(k)]) begin
                win_found = 1'b1;
                win_idx   = IN_IDX_W'(k);
            end
        end
    end

    // VC choice for the winner only: preferred VC if it has credit, else highest other.
    always_comb begin
        pref_vc  = req_pref_vc_i[win_idx];
        vc_found = 1'b0;
        sel_vc   = '0;
        if (int'(pref_vc) < int'(OUTPUT_VC_NUM) && cnt_q[pref_vc] != '0) begin
            vc_found = 1'b1;
            sel_vc   = pref_vc;
        end else begin
            // Ascending scan; the last hit is the highest-index candidate.
            for (int v = 0; v < int'(OUTPUT_VC_NUM); v++) begin
                if (VC_IDX_W'(v) != pref_vc && cnt_q[v] != '0) begin
                    vc_found = 1'b1;
                    sel_vc   = VC_IDX_W'(v);
                end
            end
        end
    end

    // Grant outputs; forced idle while reset is asserted.
    always_comb begin
        gnt_valid   = rstn && win_found && vc_found;
        gnt_o       = '0;
        gnt_vc_id_o = '0;
        gnt_in_id_o = '0;
        if (gnt_valid) begin
            gnt_o[win_idx] = 1'b1;
            gnt_vc_id_o    = sel_vc;
            gnt_in_id_o    = win_idx;
        end
    end

    // Next-state: credit counters, sticky overflow flag, round-robin pointer.
    always_comb begin
        logic dec;
        logic inc;
        dec      = 1'b0;
        inc      = 1'b0;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rr_ptr_d = rr_ptr_q;
        for (int v = 0; v < int'(OUTPUT_VC_NUM); v++) begin
            dec = gnt_valid && (sel_vc == VC_IDX_W'(v));
            inc = credit_ret_vld_i[v];
            if (dec && !inc) begin
                cnt_d[v] = cnt_q[v] - CntOne;
            end else if (inc && !dec) begin
                if (cnt_q[v] == CntMax) err_d = 1'b1;
                else                    cnt_d[v] = cnt_q[v] + CntOne;
            end
        end
        if (gnt_valid) begin
            rr_ptr_d = (win_idx == LastIn) ? '0 : win_idx + InOne;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= {OUTPUT_VC_NUM{CntMax}};
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    assign vc_credit_counter_o = cnt_q;
    assign credit_err_o        = err_q;

endmodule

// File: tb/tb_output_port_vc_allocator.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and compares.
module tb_output_port_vc_allocator;

    localparam int N   = 5;
    localparam int VCN = 4;
    localparam int D   = 2;

    logic                   clk;
    logic                   rstn;
    logic [N-1:0]           req_vld;
    logic [N-1:0][1:0]      req_pref;
    logic [VCN-1:0]         credit_ret;
    logic [N-1:0]           gnt;
    logic [1:0]             gnt_vc;
    logic [2:0]             gnt_in;
    logic [VCN-1:0][1:0]    cnt;
    logic                   err;

    output_port_vc_allocator #(
        .INPUT_NUM       (N),
        .OUTPUT_VC_NUM   (VCN),
        .OUTPUT_VC_DEPTH (D)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .req_vld_i           (req_vld),
        .req_pref_vc_i       (req_pref),
        .credit_ret_vld_i    (credit_ret),
        .gnt_o               (gnt),
        .gnt_vc_id_o         (gnt_vc),
        .gnt_in_id_o         (gnt_in),
        .vc_credit_counter_o (cnt),
        .credit_err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]        gnt;
        logic [1:0]          vc;
        logic [2:0]          in_id;
        logic [VCN-1:0][1:0] cnt;
        logic                err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: free slots per VC, next search start, overflow seen.
    int   m_cnt[VCN];
    int   m_ptr;
    bit   m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < VCN; v++) m_cnt[v] = D;
        m_ptr = 0;
        m_err = 0;
    endtask

    // One clock of stimulus; returns the input the model expects to be granted (-1 if none).
    task automatic cycle(input logic r, input logic [N-1:0] req, input logic [N-1:0][1:0] pref,
                         input logic [VCN-1:0] cr, output int won);
        exp_t e;
        int   vc;
        @(posedge clk);
        #1;
        rstn       = r;
        req_vld    = req;
        req_pref   = pref;
        credit_ret = cr;
        won = -1;
        vc  = -1;
        if (!r) model_reset();
        if (r) begin
            for (int j = 0; j < N; j++) begin
                if (won < 0 && req[(m_ptr + j) % N]) won = (m_ptr + j) % N;
            end
            if (won >= 0) begin
                if (m_cnt[int'(pref[won])] > 0) vc = int'(pref[won]);
                else begin
                    for (int v = VCN - 1; v >= 0; v--) begin
                        if (vc < 0 && v != int'(pref[won]) && m_cnt[v] > 0) vc = v;
                    end
                end
                if (vc < 0) won = -1;
            end
        end
        e.gnt   = (won >= 0) ? N'(1 << won) : '0;
        e.vc    = (won >= 0) ? 2'(vc) : 2'd0;
        e.in_id = (won >= 0) ? 3'(won) : 3'd0;
        for (int v = 0; v < VCN; v++) e.cnt[v] = 2'(m_cnt[v]);
        e.err = m_err;
        q.push_back(e);
        if (r) begin
            for (int v = 0; v < VCN; v++) begin
                int delta;
                delta = (cr[v] ? 1 : 0) - ((won >= 0 && vc == v) ? 1 : 0);
                if (delta > 0 && m_cnt[v] == D) m_err = 1;
                else m_cnt[v] = m_cnt[v] + delta;
            end
            if (won >= 0) m_ptr = (won + 1) % N;
        end
    endtask

    // Monitor: compare the DUT against the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("gnt_o", 32'(gnt), 32'(e.gnt));
                check("gnt_vc_id_o", 32'(gnt_vc), 32'(e.vc));
                check("gnt_in_id_o", 32'(gnt_in), 32'(e.in_id));
                check("vc_credit_counter_o", 32'(cnt), 32'(e.cnt));
                check("credit_err_o", 32'(err), 32'(e.err));
            end
        end
    end

    initial begin
        logic [N-1:0][1:0] p;
        logic [N-1:0]      pend;
        logic [N-1:0]      rq;
        logic [VCN-1:0]    cr;
        logic              r;
        int                won;
        int                waited;

        rstn = 1'b0;
        req_vld = '0;
        req_pref = '0;
        credit_ret = '0;
        model_reset();
        p = '0;

        // Single request after reset, preferred VC2.
        cycle(1'b0, '0, p, '0, won);
        cycle(1'b0, '1, p, '1, won);
        p[0] = 2'd2;
        cycle(1'b1, 5'b00001, p, '0, won);
        cycle(1'b1, '0, p, '0, won);

        // Rotation across inputs 0,1,3 with VC0 credit returned every cycle.
        p = '0;
        cycle(1'b0, '0, p, '0, won);
        for (int i = 0; i < 6; i++) cycle(1'b1, 5'b01011, p, 4'b0001, won);

        // Preferred VC1 exhausted, fallback to highest VC with credit.
        cycle(1'b0, '0, p, '0, won);
        p[2] = 2'd1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'b00100, p, '0, won);
        cycle(1'b1, '0, p, '0, won);

        // Drain every VC, then a credit arrives in the same cycle as a request.
        p = '0;
        cycle(1'b0, '0, p, '0, won);
        for (int i = 0; i < 8; i++) cycle(1'b1, 5'b00001, p, '0, won);
        cycle(1'b1, 5'b00001, p, 4'b0100, won);
        cycle(1'b1, 5'b00001, p, '0, won);
        cycle(1'b1, '0, p, '0, won);

        // Credit return to a full counter sets the sticky error.
        cycle(1'b0, '0, p, '0, won);
        cycle(1'b1, '0, p, 4'b0001, won);
        cycle(1'b1, '0, p, '0, won);
        cycle(1'b1, '0, p, '0, won);

        // Grant and credit on the same VC, then a mid-run reset pulse.
        cycle(1'b0, '0, p, '0, won);
        p[1] = 2'd1;
        cycle(1'b1, 5'b00010, p, '0, won);
        cycle(1'b1, 5'b00010, p, 4'b0010, won);
        cycle(1'b1, 5'b11111, p, '0, won);
        cycle(1'b0, 5'b11111, p, 4'b1111, won);
        cycle(1'b1, 5'b11111, p, '0, won);
        cycle(1'b1, '0, p, '0, won);

        // Randomized traffic; requests held until granted, occasional resets.
        pend = '0;
        p    = '0;
        for (int c = 0; c < 1500; c++) begin
            r = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    p[i]    = 2'($urandom_range(0, VCN - 1));
                end
            end
            cr = '0;
            for (int v = 0; v < VCN; v++) begin
                if ((m_cnt[v] < D && $urandom_range(0, 99) < 45) || $urandom_range(0, 99) < 3)
                    cr[v] = 1'b1;
            end
            rq = pend;
            cycle(r, rq, p, cr, won);
            if (!r) pend = '0;
            else if (won >= 0) pend[won] = 1'b0;
        end
        cycle(1'b1, '0, p, '0, won);

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
